uart_cmd_gen: RTL



---
 rtl/uart_cmd_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_gen.sv
// Host-side UART command serializer: expands one handshaked command into its
// protocol byte sequence and shifts each byte out as an LSB-first UART frame.
module uart_cmd_gen #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_opb,
  input  logic [7:0] cmd_fun,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGap} state_e;

  localparam logic [7:0] CntLast = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] GapLast = (GAP_BITS == 0) ? 3'd0 : 3'(GAP_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [1:0] typ_q;
  logic [7:0] addr_q, data_q, opb_q, fun_q;
  logic       par_en_q, par_typ_q;
  logic       tx_q, tx_d;
  logic       busy_q, done_q, done_d, ready_q;
  logic       accept, last_tick, byte_end;
  logic [1:0] last_byte;
  logic [7:0] cur_byte_d;

  function automatic logic [7:0] byte_at(input logic [1:0] typ, input logic [1:0] idx,
                                         input logic [7:0] addr, input logic [7:0] data,
                                         input logic [7:0] opb, input logic [7:0] fun);
    logic [7:0] b;
    b = 8'h00;
    unique case (typ)
      2'd0: b = (idx == 2'd0) ? 8'hAA : (idx == 2'd1) ? addr : data;
      2'd1: b = (idx == 2'd0) ? 8'hBB : addr;
      2'd2: b = (idx == 2'd0) ? 8'hCC : (idx == 2'd1) ? data : (idx == 2'd2) ? opb : fun;
      default: b = (idx == 2'd0) ? 8'hDD : fun;
    endcase
    return b;
  endfunction

  assign accept    = cmd_valid && ready_q;
  assign last_tick = (cnt_q == CntLast);

  always_comb begin
    unique case (typ_q)
      2'd0:    last_byte = 2'd2;
      2'd2:    last_byte = 2'd3;
      default: last_byte = 2'd1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = last_tick ? 8'd0 : cnt_q + 8'd1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    byte_end   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (accept) begin
          state_d    = StStart;
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
        end
      end
      StStart: if (last_tick) begin
        state_d   = StData;
        bit_idx_d = 3'd0;
      end
      StData: if (last_tick) begin
        if (bit_idx_q == 3'd7) state_d = par_en_q ? StParity : StStop;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      StParity: if (last_tick) state_d = StStop;
      StStop: if (last_tick) begin
        if (GAP_BITS == 0) begin
          byte_end = 1'b1;
        end else begin
          state_d   = StGap;
          bit_idx_d = 3'd0;
        end
      end
      StGap: if (last_tick) begin
        // bit_idx doubles as the gap-period counter here
        if (bit_idx_q == GapLast) byte_end = 1'b1;
        else                      bit_idx_d = bit_idx_q + 3'd1;
      end
      default: state_d = StIdle;
    endcase
    if (byte_end) begin
      if (byte_idx_q < last_byte) begin
        byte_idx_d = byte_idx_q + 2'd1;
        state_d    = StStart;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  // Line level is computed for the upcoming cycle so tx_out comes straight from a flop.
  always_comb begin
    cur_byte_d = byte_at(typ_q, byte_idx_d, addr_q, data_q, opb_q, fun_q);
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = cur_byte_d[bit_idx_d];
      StParity: tx_d = par_typ_q ? ~^cur_byte_d : ^cur_byte_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= done_d;
      ready_q    <= (state_d == StIdle);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      typ_q     <= 2'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      opb_q     <= 8'd0;
      fun_q     <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (accept) begin
      typ_q     <= cmd_type;
      addr_q    <= cmd_addr;
      data_q    <= cmd_data;
      opb_q     <= cmd_opb;
      fun_q     <= cmd_fun;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule
